// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor with a ripple-carry chain, and keep the difference only when it is non-negative.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   p,
  input  logic             a_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] subtrahend;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           unused_p_msb;

  // The partial remainder is always below the divisor, so its top bit never reaches the shift.
  assign unused_p_msb = p[WIDTH];

  assign shifted    = {p[WIDTH-1:0], a_msb};
  assign subtrahend = ~{1'b0, d};

  always_comb begin
    diff  = '0;
    carry = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      diff[i] = shifted[i] ^ subtrahend[i] ^ carry;
      carry   = (shifted[i] & subtrahend[i]) | (carry & (shifted[i] ^ subtrahend[i]));
    end
  end

  assign q_bit  = ~diff[WIDTH];
  assign p_next = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, START/BUSY/DONE handshake.
// Optional DIVIDER_ZERO_ERR_EN: a zero divisor finishes in one cycle with Q=0, R=X, ERR=1.
//
// state | meaning
// IDLE  | waiting for start; q/r hold the last result
// RUN   | one restoring step per clock, cnt counts remaining steps
// FIN   | done pulse; start here chains straight into the next division
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             q_bit;
  logic             accept;
  logic             last_step;
  logic             zero_skip;
  logic             err_q;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .a_msb  (a[WIDTH-1]),
    .d      (dvs),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  assign accept    = start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == CW'(1));

`ifdef DIVIDER_ZERO_ERR_EN
  assign zero_skip = (y == '0);
`else
  assign zero_skip = 1'b0;
`endif

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, FIN: begin
        done = (state == FIN);
        if (accept) state_next = zero_skip ? FIN : RUN;
        else        state_next = IDLE;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = FIN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p     <= '0;
      a     <= '0;
      dvs   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        p     <= '0;
        a     <= x;
        dvs   <= y;
        cnt   <= CW'(WIDTH);
        err_q <= zero_skip;
        if (zero_skip) begin
          q <= '0;
          r <= x;
        end
      end else if (state == RUN) begin
        p   <= p_next;
        a   <= {a[WIDTH-2:0], q_bit};
        cnt <= cnt - CW'(1);
        // Results are published only on the final step so they stay stable while running.
        if (cnt == CW'(1)) begin
          q <= {a[WIDTH-2:0], q_bit};
          r <= p_next[WIDTH-1:0];
        end
      end
    end
  end

  assign err = err_q;

endmodule
